// File: rtl/activation_cache.sv
// Dilated causal history buffer: stores the last L samples and gathers K dilated taps per accept.
// Optional macro ACTIVATION_CACHE_WARMUP_SUPPRESS_EN holds out_v low until the buffer is full.
module activation_cache #(
    parameter int unsigned W        = 16,
    parameter int unsigned C        = 4,
    parameter int unsigned K        = 2,
    parameter int unsigned DILATION = 4,
    localparam int unsigned D       = K * C,
    localparam int unsigned L       = (K - 1) * DILATION + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [C*W-1:0]   in_sample,
    input  logic             in_v,
    output logic             in_ready,
    output logic [D*W-1:0]   packed_out,
    output logic             out_v
);

    localparam int unsigned PW = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned FW = $clog2(L + 1);

    typedef enum logic [1:0] {StIdle, StGather, StEmit} state_t;

    state_t           state_q, state_d;
    logic [C*W-1:0]   mem   [L];
    logic [C*W-1:0]   stage [K];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    base;
    logic [PW-1:0]    rd_idx;
    logic [KW-1:0]    tap;
    logic [FW-1:0]    fill;
    logic [D*W-1:0]   packed_stage;
    logic             accept;
    logic             emit_valid;
    int unsigned      tap_off;
    int unsigned      rd_idx_full;

    assign in_ready = (state_q == StIdle);
    assign accept   = in_v && in_ready;

`ifdef ACTIVATION_CACHE_WARMUP_SUPPRESS_EN
    assign emit_valid = (32'(fill) == L);
`else
    assign emit_valid = 1'b1;
`endif

    // Wrap the read index by adding L instead of going negative.
    always_comb begin
        tap_off = (K - 1 - 32'(tap)) * DILATION;
        if (32'(base) >= tap_off) begin
            rd_idx_full = 32'(base) - tap_off;
        end else begin
            rd_idx_full = 32'(base) + L - tap_off;
        end
        rd_idx = PW'(rd_idx_full);
    end

    // Tap k lands in element slots k*C .. k*C+C-1, MSB-first.
    always_comb begin
        packed_stage = '0;
        for (int k = 0; k < K; k++) begin
            packed_stage[C*W*(K-1-k) +: C*W] = stage[k];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = StGather;
            StGather: if (32'(tap) == K - 1) state_d = StEmit;
            StEmit:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr     <= '0;
            base       <= '0;
            tap        <= '0;
            fill       <= '0;
            packed_out <= '0;
            out_v      <= 1'b0;
            for (int i = 0; i < L; i++) mem[i] <= '0;
            for (int k = 0; k < K; k++) stage[k] <= '0;
        end else begin
            state_q <= state_d;
            out_v   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        mem[wr_ptr] <= in_sample;
                        base        <= wr_ptr;
                        wr_ptr      <= (32'(wr_ptr) == L - 1) ? '0 : wr_ptr + PW'(1);
                        tap         <= '0;
                        if (32'(fill) < L) fill <= fill + FW'(1);
                    end
                end
                StGather: begin
                    stage[tap] <= mem[rd_idx];
                    tap        <= tap + KW'(1);
                end
                StEmit: begin
                    packed_out <= packed_stage;
                    out_v      <= emit_valid;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_activation_cache.sv
// Scoreboard bench for activation_cache (W=16, C=1, K=2, DILATION=4, L=5).
module tb_activation_cache;

    localparam int W   = 16;
    localparam int C   = 1;
    localparam int K   = 2;
    localparam int DIL = 4;
    localparam int D   = K * C;
    localparam int L   = (K - 1) * DIL + 1;

`ifdef ACTIVATION_CACHE_WARMUP_SUPPRESS_EN
    localparam bit SUPPRESS = 1'b1;
`else
    localparam bit SUPPRESS = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [C*W-1:0] in_sample;
    logic           in_v;
    logic           in_ready;
    logic [D*W-1:0] packed_out;
    logic           out_v;

    activation_cache #(
        .W        (W),
        .C        (C),
        .K        (K),
        .DILATION (DIL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_sample  (in_sample),
        .in_v       (in_v),
        .in_ready   (in_ready),
        .packed_out (packed_out),
        .out_v      (out_v)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc = -1;
    bit stream_mode = 1'b0;

    logic [W-1:0]   hist  [$];
    logic [D*W-1:0] exp_q [$];
    int             acc_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Expected gather from the accepted-sample history, zero before the first sample.
    function automatic logic [D*W-1:0] model_out();
        logic [D*W-1:0] r;
        int n;
        int idx;
        r = '0;
        n = hist.size();
        for (int k = 0; k < K; k++) begin
            idx = n - 1 - (K - 1 - k) * DIL;
            if (idx >= 0) r[W*(D-1-k) +: W] = hist[idx];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        logic [D*W-1:0] e;
        int a;
        if (!rst) begin
            if (in_v && in_ready) begin
                hist.push_back(in_sample);
                if (stream_mode && last_acc >= 0) check_eq("accept_spacing", 64'(cyc - last_acc), 64'(K + 2));
                last_acc = cyc;
                if (!SUPPRESS || hist.size() >= L) begin
                    exp_q.push_back(model_out());
                    acc_q.push_back(cyc);
                end
            end
            if (out_v) begin
                check_eq("in_ready_with_out_v", 64'(in_ready), 64'd1);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out_v", 64'(out_v), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check_eq("packed_out", 64'(packed_out), 64'(e));
                    check_eq("latency", 64'(cyc - a), 64'(K + 2));
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_v = 1'b0;
        hist.delete();
        exp_q.delete();
        acc_q.delete();
        #1;
        check_eq("rst_packed_out", 64'(packed_out), 64'd0);
        check_eq("rst_out_v", 64'(out_v), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic send(input logic [W-1:0] v, input bit hold);
        int t;
        t = 0;
        in_sample = v;
        in_v = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        if (!hold) in_v = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        repeat (K + 3) @(posedge clk);
        #1;
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_v = 1'b0;
        in_sample = '0;
        do_reset();

        // Sequential samples 1..12 including pointer wrap.
        for (int v = 1; v <= 12; v++) send(W'(v), 1'b0);
        drain();

        // in_v held high: one accept per K+2 cycles, values stay gap-free.
        do_reset();
        stream_mode = 1'b1;
        last_acc = -1;
        for (int v = 1; v <= 8; v++) send(W'(v), 1'b1);
        in_v = 1'b0;
        stream_mode = 1'b0;
        drain();

        // Negative data passes bit-exact.
        do_reset();
        send(16'hFFFF, 1'b0);
        for (int i = 0; i < 4; i++) send(16'h8000, 1'b0);
        drain();

        // Reset in the middle of GATHER for sample 7.
        do_reset();
        for (int v = 1; v <= 6; v++) send(W'(v), 1'b0);
        drain();
        send(16'd7, 1'b0);
        @(posedge clk);
        #1;
        do_reset();
        check_eq("post_rst_packed_out", 64'(packed_out), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("post_rst_no_out_v", 64'(out_v), 64'd0);
        end
        send(16'h000A, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
